// File: rtl/round_sequencer_pkg.sv
// Shared definitions for the round sequencer: phase codes, segment patterns,
// default phase lengths and the countdown-width helper.
package round_sequencer_pkg;

  typedef logic [2:0] phase_t;
  typedef logic [7:0] seg_t;

  localparam phase_t PH_IDLE      = 3'd0;
  localparam phase_t PH_COUNTDOWN = 3'd1;
  localparam phase_t PH_SHOW      = 3'd2;
  localparam phase_t PH_ANSWER    = 3'd3;
  localparam phase_t PH_POST      = 3'd4;
  localparam phase_t PH_DONE      = 3'd5;

  localparam seg_t SEG_DASH  = 8'hBF;
  localparam seg_t SEG_BLANK = 8'hFF;

  localparam int unsigned DEF_COUNTDOWN_SECS = 3;
  localparam int unsigned DEF_SHOW_SECS      = 10;
  localparam int unsigned DEF_ANSWER_SECS    = 15;
  localparam int unsigned DEF_POST_SECS      = 5;
  localparam int unsigned DEF_NUM_ROUNDS     = 4;

  // Bits needed to hold the longest of the four phase lengths.
  function automatic int unsigned sec_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake between the round sequencer and the answer-period block.
interface round_sequencer_if;
  import round_sequencer_pkg::*;

  logic answerSig;
  logic stopCount;
  logic postSig;
  seg_t answerSeg0;
  seg_t answerSeg1;
  seg_t answerSeg2;
  seg_t answerSeg3;

  modport master (
    output answerSig,
    input  stopCount, postSig, answerSeg0, answerSeg1, answerSeg2, answerSeg3
  );

  modport slave (
    input  answerSig,
    output stopCount, postSig, answerSeg0, answerSeg1, answerSeg2, answerSeg3
  );

endinterface

// File: rtl/seg_decode.sv
// Hex digit to active-low seven-segment pattern (bit7 = dp, kept off).
module seg_decode
  import round_sequencer_pkg::*;
(
  input  logic [3:0] i_value,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_value)
      4'h0: o_seg = 8'hC0;
      4'h1: o_seg = 8'hF9;
      4'h2: o_seg = 8'hA4;
      4'h3: o_seg = 8'hB0;
      4'h4: o_seg = 8'h99;
      4'h5: o_seg = 8'h92;
      4'h6: o_seg = 8'h82;
      4'h7: o_seg = 8'hF8;
      4'h8: o_seg = 8'h80;
      4'h9: o_seg = 8'h90;
      4'hA: o_seg = 8'h88;
      4'hB: o_seg = 8'h83;
      4'hC: o_seg = 8'hC6;
      4'hD: o_seg = 8'hA1;
      4'hE: o_seg = 8'h86;
      4'hF: o_seg = 8'h8E;
    endcase
  end

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: countdown, symbol show, answer window and result hold
// per round, with a registered, phase-arbitrated four-digit display.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int unsigned COUNTDOWN_SECS = DEF_COUNTDOWN_SECS,
  parameter int unsigned SHOW_SECS      = DEF_SHOW_SECS,
  parameter int unsigned ANSWER_SECS    = DEF_ANSWER_SECS,
  parameter int unsigned POST_SECS      = DEF_POST_SECS,
  parameter int unsigned NUM_ROUNDS     = DEF_NUM_ROUNDS
) (
  input  logic                     Clk100M,
  input  logic                     Reset_n,
  input  logic                     Clk1Hz,
  input  logic                     startSig,
  round_sequencer_if.master        ans,
  output logic                     showEn,
  output phase_t                   phase,
  output logic [2:0]               roundNum,
  output logic                     busy,
  output seg_t                     seg0,
  output seg_t                     seg1,
  output seg_t                     seg2,
  output seg_t                     seg3
);

  localparam int unsigned SEC_W = sec_width(COUNTDOWN_SECS, SHOW_SECS, ANSWER_SECS, POST_SECS);
  typedef logic [SEC_W-1:0] sec_t;

  localparam sec_t       LOAD_CD    = sec_t'(COUNTDOWN_SECS);
  localparam sec_t       LOAD_SHOW  = sec_t'(SHOW_SECS);
  localparam sec_t       LOAD_ANS   = sec_t'(ANSWER_SECS);
  localparam sec_t       LOAD_POST  = sec_t'(POST_SECS);
  localparam sec_t       SEC_ONE    = sec_t'(1);
  localparam logic [2:0] LAST_ROUND = 3'(NUM_ROUNDS - 1);

  phase_t     r_state;
  sec_t       r_sec_left;
  logic [2:0] r_round;
  logic       r_answer_sig;
  logic       r_show_en;
  logic       r_busy;
  phase_t     r_phase;
  seg_t       r_seg0, r_seg1, r_seg2, r_seg3;

  phase_t     w_state_d;
  sec_t       w_sec_d;
  logic [2:0] w_round_d;
  logic       w_tick_last;
  logic [3:0] w_digit;
  seg_t       w_digit_seg;
  seg_t       w_seg0_d, w_seg1_d, w_seg2_d, w_seg3_d;

  assign w_tick_last = Clk1Hz && (r_sec_left == SEC_ONE);
  assign w_digit     = 4'(r_sec_left);

  // Every exit loads the next phase's length, so a tick on the exit edge is
  // never charged against the phase being entered.
  always_comb begin
    w_state_d = r_state;
    w_sec_d   = r_sec_left;
    w_round_d = r_round;
    if (Clk1Hz && (r_sec_left > SEC_ONE)) w_sec_d = r_sec_left - SEC_ONE;
    case (r_state)
      PH_IDLE, PH_DONE: begin
        if (startSig) begin
          w_state_d = PH_COUNTDOWN;
          w_sec_d   = LOAD_CD;
          w_round_d = '0;
        end
      end
      PH_COUNTDOWN: begin
        if (w_tick_last) begin
          w_state_d = PH_SHOW;
          w_sec_d   = LOAD_SHOW;
        end
      end
      PH_SHOW: begin
        if (w_tick_last) begin
          w_state_d = PH_ANSWER;
          w_sec_d   = LOAD_ANS;
        end
      end
      PH_ANSWER: begin
        if (w_tick_last || ans.postSig || ans.stopCount) begin
          w_state_d = PH_POST;
          w_sec_d   = LOAD_POST;
        end
      end
      PH_POST: begin
        if (w_tick_last) begin
          if (r_round == LAST_ROUND) begin
            w_state_d = PH_DONE;
            w_sec_d   = '0;
          end else begin
            w_state_d = PH_COUNTDOWN;
            w_sec_d   = LOAD_CD;
            w_round_d = r_round + 3'd1;
          end
        end
      end
      default: begin
        w_state_d = PH_IDLE;
        w_sec_d   = '0;
        w_round_d = '0;
      end
    endcase
  end

  seg_decode u_seg_decode (
    .i_value (w_digit),
    .o_seg   (w_digit_seg)
  );

  always_comb begin
    w_seg0_d = SEG_DASH;
    w_seg1_d = SEG_DASH;
    w_seg2_d = SEG_DASH;
    w_seg3_d = SEG_DASH;
    case (r_state)
      PH_COUNTDOWN: begin
        w_seg0_d = w_digit_seg;
        w_seg1_d = SEG_BLANK;
        w_seg2_d = SEG_BLANK;
        w_seg3_d = SEG_BLANK;
      end
      PH_SHOW: begin
        w_seg0_d = SEG_BLANK;
        w_seg1_d = SEG_BLANK;
        w_seg2_d = SEG_BLANK;
        w_seg3_d = SEG_BLANK;
      end
      PH_ANSWER, PH_POST: begin
        w_seg0_d = ans.answerSeg0;
        w_seg1_d = ans.answerSeg1;
        w_seg2_d = ans.answerSeg2;
        w_seg3_d = ans.answerSeg3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk100M or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= PH_IDLE;
      r_sec_left   <= '0;
      r_round      <= '0;
      r_answer_sig <= 1'b0;
      r_show_en    <= 1'b0;
      r_busy       <= 1'b0;
      r_phase      <= PH_IDLE;
      r_seg0       <= SEG_DASH;
      r_seg1       <= SEG_DASH;
      r_seg2       <= SEG_DASH;
      r_seg3       <= SEG_DASH;
    end else begin
      r_state      <= w_state_d;
      r_sec_left   <= w_sec_d;
      r_round      <= w_round_d;
      r_answer_sig <= (w_state_d == PH_ANSWER) && (r_state != PH_ANSWER);
      r_show_en    <= (r_state == PH_SHOW);
      r_busy       <= (r_state != PH_IDLE) && (r_state != PH_DONE);
      r_phase      <= r_state;
      r_seg0       <= w_seg0_d;
      r_seg1       <= w_seg1_d;
      r_seg2       <= w_seg2_d;
      r_seg3       <= w_seg3_d;
    end
  end

  assign ans.answerSig = r_answer_sig;
  assign showEn        = r_show_en;
  assign busy          = r_busy;
  assign phase         = r_phase;
  assign roundNum      = r_round;
  assign seg0          = r_seg0;
  assign seg1          = r_seg1;
  assign seg2          = r_seg2;
  assign seg3          = r_seg3;

endmodule

// File: tb/tb_round_sequencer.sv
// Randomized bench for round_sequencer against a tick-counting game model.
module tb_round_sequencer;
  import round_sequencer_pkg::*;

  localparam int TickCycles = 100;
  localparam int NumRounds  = int'(DEF_NUM_ROUNDS);

  logic       Clk100M  = 1'b0;
  logic       Reset_n  = 1'b0;
  logic       Clk1Hz   = 1'b0;
  logic       startSig = 1'b0;
  logic       showEn, busy;
  phase_t     phase;
  logic [2:0] roundNum;
  seg_t       seg0, seg1, seg2, seg3;

  round_sequencer_if ans_if ();

  round_sequencer dut (
    .Clk100M  (Clk100M),
    .Reset_n  (Reset_n),
    .Clk1Hz   (Clk1Hz),
    .startSig (startSig),
    .ans      (ans_if),
    .showEn   (showEn),
    .phase    (phase),
    .roundNum (roundNum),
    .busy     (busy),
    .seg0     (seg0),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3)
  );

  always #5 Clk100M = ~Clk100M;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase lengths in seconds, successor of each timed phase, digit glyphs.
  int     dur  [6] = '{0, int'(DEF_COUNTDOWN_SECS), int'(DEF_SHOW_SECS),
                       int'(DEF_ANSWER_SECS), int'(DEF_POST_SECS), 0};
  phase_t succ [6] = '{PH_IDLE, PH_SHOW, PH_ANSWER, PH_POST, PH_COUNTDOWN, PH_DONE};
  seg_t   glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  phase_t m_phase = PH_IDLE;
  int     m_left  = 0;
  int     m_round = 0;

  int cyc_cnt     = 0;
  int post_mode   = 0;
  int post_after  = 0;
  bit start_req   = 1'b0;
  bit noise_start = 1'b0;
  int ans_ticks   = 0;

  int     dut_ans_ticks = 0, dut_post_ticks = 0;
  int     last_ans_ticks = 0, last_post_ticks = 0;
  int     answer_pulses = 0, post_entries = 0;
  phase_t prev_obs = PH_IDLE;

  function automatic void model_enter(input phase_t ph);
    m_phase = ph;
    m_left  = dur[ph];
  endfunction

  task automatic cycle();
    bit          tick, post, stop, start, exit_now;
    seg_t        as [4];
    phase_t      o_phase;
    int          o_left;
    seg_t        e0, e1, e2, e3;
    logic [40:0] got_v, exp_v;
    @(negedge Clk100M);
    tick = (cyc_cnt % TickCycles) == (TickCycles - 1);
    cyc_cnt++;
    start     = start_req;
    start_req = 1'b0;
    if (noise_start && m_phase != PH_IDLE && m_phase != PH_DONE)
      start = ($urandom_range(0, 39) == 0);
    post = 1'b0;
    stop = 1'b0;
    case (post_mode)
      1: post = (m_phase == PH_ANSWER) && (ans_ticks >= post_after) && !tick;
      2: begin
        post = (m_phase == PH_ANSWER) && tick && (m_left == 1);
        stop = post;
      end
      3: begin
        post = ($urandom_range(0, 599) == 0);
        stop = ($urandom_range(0, 599) == 0);
      end
      default: ;
    endcase
    foreach (as[i]) as[i] = seg_t'($urandom);
    Clk1Hz            = tick;
    startSig          = start;
    ans_if.postSig    = post;
    ans_if.stopCount  = stop;
    ans_if.answerSeg0 = as[0];
    ans_if.answerSeg1 = as[1];
    ans_if.answerSeg2 = as[2];
    ans_if.answerSeg3 = as[3];
    @(posedge Clk100M);
    o_phase = m_phase;
    o_left  = m_left;
    if (m_phase == PH_IDLE || m_phase == PH_DONE) begin
      if (start) begin
        m_round = 0;
        model_enter(PH_COUNTDOWN);
      end
    end else begin
      exit_now = (m_phase == PH_ANSWER) && (post || stop);
      if (tick) begin
        if (m_phase == PH_ANSWER) ans_ticks++;
        if (m_left == 1) exit_now = 1'b1;
        else m_left--;
      end
      if (exit_now) begin
        if (m_phase != PH_POST) model_enter(succ[m_phase]);
        else if (m_round == NumRounds - 1) model_enter(PH_DONE);
        else begin
          m_round++;
          model_enter(PH_COUNTDOWN);
        end
      end
    end
    if (m_phase == PH_ANSWER && o_phase != PH_ANSWER) ans_ticks = 0;
    // Display reflects the phase held during the cycle just ended.
    case (o_phase)
      PH_COUNTDOWN: begin
        e0 = glyph[o_left]; e1 = SEG_BLANK; e2 = SEG_BLANK; e3 = SEG_BLANK;
      end
      PH_SHOW: begin
        e0 = SEG_BLANK; e1 = SEG_BLANK; e2 = SEG_BLANK; e3 = SEG_BLANK;
      end
      PH_ANSWER, PH_POST: begin
        e0 = as[0]; e1 = as[1]; e2 = as[2]; e3 = as[3];
      end
      default: begin
        e0 = SEG_DASH; e1 = SEG_DASH; e2 = SEG_DASH; e3 = SEG_DASH;
      end
    endcase
    exp_v = {o_phase, 3'(m_round), (m_phase == PH_ANSWER) && (o_phase != PH_ANSWER),
             (o_phase == PH_SHOW), (o_phase != PH_IDLE) && (o_phase != PH_DONE),
             e0, e1, e2, e3};
    #1;
    got_v = {phase, roundNum, ans_if.answerSig, showEn, busy, seg0, seg1, seg2, seg3};
    check_eq("cycle_outputs", 64'(got_v), 64'(exp_v));
    if (ans_if.answerSig) answer_pulses++;
    if (phase == PH_POST && prev_obs != PH_POST) begin
      post_entries++;
      dut_post_ticks = 0;
    end
    if (phase == PH_ANSWER && prev_obs != PH_ANSWER) dut_ans_ticks = 0;
    if (tick && phase == PH_ANSWER) dut_ans_ticks++;
    if (tick && phase == PH_POST) dut_post_ticks++;
    if (phase != PH_ANSWER && prev_obs == PH_ANSWER) last_ans_ticks = dut_ans_ticks;
    if (phase != PH_POST && prev_obs == PH_POST) last_post_ticks = dut_post_ticks;
    prev_obs = phase;
  endtask

  task automatic run_until(input phase_t ph, input int rnd, input int max_cycles,
                           input string tag);
    int n = 0;
    while (!(phase == ph && int'(roundNum) == rnd) && n < max_cycles) begin
      cycle();
      n++;
    end
    check_eq(tag, 64'({phase, roundNum}), 64'({ph, 3'(rnd)}));
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_phase"}, 64'(phase), 64'(PH_IDLE));
    check_eq({pfx, "_round"}, 64'(roundNum), 64'd0);
    check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
    check_eq({pfx, "_show"}, 64'(showEn), 64'd0);
    check_eq({pfx, "_answer"}, 64'(ans_if.answerSig), 64'd0);
    check_eq({pfx, "_segs"}, 64'({seg0, seg1, seg2, seg3}), 64'h00000000_BFBFBFBF);
  endtask

  initial begin
    int pulses_before;
    ans_if.postSig    = 1'b0;
    ans_if.stopCount  = 1'b0;
    ans_if.answerSeg0 = '0;
    ans_if.answerSeg1 = '0;
    ans_if.answerSeg2 = '0;
    ans_if.answerSeg3 = '0;
    repeat (3) @(posedge Clk100M);
    #1;
    check_reset_vals("reset");
    @(negedge Clk100M);
    Reset_n = 1'b1;
    repeat (20) cycle();

    // Round 0: answer window times out.
    start_req = 1'b1;
    post_mode = 0;
    run_until(PH_COUNTDOWN, 1, 6000, "reach_round1");
    check_eq("timeout_answer_ticks", 64'(last_ans_ticks), 64'd15);
    check_eq("post_ticks_r0", 64'(last_post_ticks), 64'd5);

    // Round 1: result posted after four ticks.
    post_mode  = 1;
    post_after = 4;
    run_until(PH_COUNTDOWN, 2, 6000, "reach_round2");
    check_eq("early_post_ticks", 64'(last_ans_ticks), 64'd4);
    check_eq("post_entries_r1", 64'(post_entries), 64'd2);

    // Round 2: postSig, stopCount and the final tick all coincide.
    post_mode = 2;
    run_until(PH_COUNTDOWN, 3, 6000, "reach_round3");
    check_eq("coincide_answer_ticks", 64'(last_ans_ticks), 64'd15);
    check_eq("coincide_post_ticks", 64'(last_post_ticks), 64'd5);
    check_eq("post_entries_r2", 64'(post_entries), 64'd3);

    // Round 3: random post/stop everywhere, stray startSig while busy.
    post_mode   = 3;
    noise_start = 1'b1;
    run_until(PH_DONE, 3, 6000, "reach_done");
    noise_start = 1'b0;
    repeat (10) cycle();
    check_eq("done_phase", 64'(phase), 64'(PH_DONE));
    check_eq("done_busy", 64'(busy), 64'd0);
    check_eq("done_segs", 64'({seg0, seg1, seg2, seg3}), 64'h00000000_BFBFBFBF);
    check_eq("answer_pulses", 64'(answer_pulses), 64'd4);
    check_eq("post_entries", 64'(post_entries), 64'd4);

    start_req = 1'b1;
    cycle();
    cycle();
    check_eq("restart_round", 64'(roundNum), 64'd0);
    check_eq("restart_phase", 64'(phase), 64'(PH_COUNTDOWN));

    run_until(PH_SHOW, 0, 2000, "reach_show");
    repeat (30) cycle();
    start_req = 1'b1;
    repeat (6) cycle();
    check_eq("show_ignores_start", 64'({phase, showEn}), 64'({PH_SHOW, 1'b1}));

    // Asynchronous reset in the middle of SHOW.
    #2;
    Reset_n          = 1'b0;
    Clk1Hz           = 1'b0;
    startSig         = 1'b0;
    ans_if.postSig   = 1'b0;
    ans_if.stopCount = 1'b0;
    #1;
    check_reset_vals("midrst");
    m_phase       = PH_IDLE;
    m_left        = 0;
    m_round       = 0;
    prev_obs      = PH_IDLE;
    pulses_before = answer_pulses;
    repeat (3) @(posedge Clk100M);
    @(negedge Clk100M);
    Reset_n = 1'b1;
    repeat (150) cycle();
    check_eq("no_pulse_after_reset", 64'(answer_pulses), 64'(pulses_before));
    check_eq("idle_after_reset", 64'(phase), 64'(PH_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
